// File: rtl/ram_arbiter_if.sv
// Requester, RAM and status signals of the two-port RAM arbiter.
// slave is the arbiter side; master is the requester/RAM side.
interface ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wd0;
  logic              ack0;
  logic [DATA_W-1:0] rd0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wd1;
  logic              ack1;
  logic [DATA_W-1:0] rd1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              gnt_id;

  modport slave (
    input  req0, we0, addr0, wd0, req1, we1, addr1, wd1, mem_rdata,
    output ack0, rd0, ack1, rd1, mem_addr, mem_wd, mem_we, busy, gnt_id
  );

  modport master (
    output req0, we0, addr0, wd0, req1, we1, addr1, wd1, mem_rdata,
    input  ack0, rd0, ack1, rd1, mem_addr, mem_wd, mem_we, busy, gnt_id
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter serialising two requesters onto one single-port RAM.
// All outputs are registered; read data returns RD_LAT cycles after ACCESS.
module ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24,
  parameter int RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  ram_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wd;
  logic [DATA_W-1:0] w_mem_wd_nxt;
  logic              r_mem_we;
  logic              w_mem_we_nxt;
  logic              r_op_we;
  logic              w_op_we_nxt;
  logic              r_gnt_id;
  logic              w_gnt_id_nxt;
  logic              r_last_grant;
  logic              w_last_grant_nxt;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_nxt;
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] w_rd0_nxt;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] w_rd1_nxt;
  logic              r_ack0;
  logic              w_ack0_nxt;
  logic              r_ack1;
  logic              w_ack1_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              w_pick;

  // On a tie the port that was not served last wins.
  assign w_pick = (io_bus.req0 && io_bus.req1) ? ~r_last_grant : io_bus.req1;

  always_comb begin
    w_state_nxt      = r_state;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wd_nxt     = r_mem_wd;
    w_mem_we_nxt     = 1'b0;
    w_op_we_nxt      = r_op_we;
    w_gnt_id_nxt     = r_gnt_id;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    w_rd0_nxt        = r_rd0;
    w_rd1_nxt        = r_rd1;
    w_ack0_nxt       = 1'b0;
    w_ack1_nxt       = 1'b0;

    case (r_state)
      IDLE: begin
        if (io_bus.req0 || io_bus.req1) begin
          w_state_nxt      = ACCESS;
          w_gnt_id_nxt     = w_pick;
          w_last_grant_nxt = w_pick;
          w_mem_addr_nxt   = w_pick ? io_bus.addr1 : io_bus.addr0;
          w_mem_wd_nxt     = w_pick ? io_bus.wd1 : io_bus.wd0;
          w_op_we_nxt      = w_pick ? io_bus.we1 : io_bus.we0;
          w_mem_we_nxt     = w_pick ? io_bus.we1 : io_bus.we0;
        end
      end
      ACCESS: begin
        if (r_op_we) begin
          w_state_nxt = DONE;
          w_ack0_nxt  = ~r_gnt_id;
          w_ack1_nxt  = r_gnt_id;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (r_cnt != 2'd0) begin
          w_cnt_nxt = r_cnt - 2'd1;
        end else begin
          w_state_nxt = DONE;
          w_ack0_nxt  = ~r_gnt_id;
          w_ack1_nxt  = r_gnt_id;
          if (r_gnt_id) begin
            w_rd1_nxt = io_bus.mem_rdata;
          end else begin
            w_rd0_nxt = io_bus.mem_rdata;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_mem_addr   <= '0;
      r_mem_wd     <= '0;
      r_mem_we     <= 1'b0;
      r_op_we      <= 1'b0;
      r_gnt_id     <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= 2'd0;
      r_rd0        <= '0;
      r_rd1        <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wd     <= w_mem_wd_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_op_we      <= w_op_we_nxt;
      r_gnt_id     <= w_gnt_id_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rd0        <= w_rd0_nxt;
      r_rd1        <= w_rd1_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign io_bus.mem_addr = r_mem_addr;
  assign io_bus.mem_wd   = r_mem_wd;
  assign io_bus.mem_we   = r_mem_we;
  assign io_bus.rd0      = r_rd0;
  assign io_bus.rd1      = r_rd1;
  assign io_bus.ack0     = r_ack0;
  assign io_bus.ack1     = r_ack1;
  assign io_bus.busy     = r_busy;
  assign io_bus.gnt_id   = r_gnt_id;

endmodule
